// File: rtl/uart_pkg.sv
// Shared definitions for the UART-driven ALU controller:
// FSM state encoding and default data/opcode widths.
package uart_pkg;

    localparam int DBIT_DEF = 8;
    localparam int OPW_DEF  = 6;

    typedef enum logic [2:0] {
        S_WAIT_A  = 3'd0,
        S_WAIT_B  = 3'd1,
        S_WAIT_OP = 3'd2,
        S_EXEC    = 3'd3,
        S_SEND    = 3'd4,
        S_WAIT_TX = 3'd5
    } state_e;

endpackage

// File: rtl/uart_alu_ctrl_if.sv
// Bus between the controller, UART rx/tx and the external ALU.
// master: the controller; slave: the surrounding UART/ALU side.
interface uart_alu_ctrl_if
    import uart_pkg::*;
#(
    parameter int DBIT = DBIT_DEF,
    parameter int OPW  = OPW_DEF
);
    logic            rx_done_tick;
    logic [DBIT-1:0] rx_data;
    logic [DBIT-1:0] alu_result;
    logic            tx_done_tick;
    logic [DBIT-1:0] alu_a;
    logic [DBIT-1:0] alu_b;
    logic [OPW-1:0]  alu_op;
    logic            tx_start;
    logic [DBIT-1:0] tx_data;
    logic            busy;
    logic            overrun_tick;
    logic            timeout_tick;

    modport master (
        input  rx_done_tick, rx_data, alu_result, tx_done_tick,
        output alu_a, alu_b, alu_op, tx_start, tx_data,
        output busy, overrun_tick, timeout_tick
    );

    modport slave (
        output rx_done_tick, rx_data, alu_result, tx_done_tick,
        input  alu_a, alu_b, alu_op, tx_start, tx_data,
        input  busy, overrun_tick, timeout_tick
    );

endinterface

// File: rtl/uart_gap_timer.sv
// Inter-byte gap counter: counts while enabled, flags expiry at
// CYCLES-1; clear has priority over counting.
module uart_gap_timer #(
    parameter int CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);
    localparam int CW = (CYCLES < 2) ? 1 : $clog2(CYCLES);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expire_o = enable_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (enable_i && !expire_o)
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_alu_ctrl.sv
// Collects A, B, opcode bytes from a UART, latches the ALU result and
// sends it back. Optional inter-byte timeout under `RX_TIMEOUT_EN.
module uart_alu_ctrl
    import uart_pkg::*;
#(
    parameter int DBIT           = DBIT_DEF,
    parameter int OPW            = OPW_DEF,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic            clk,
    input  logic            reset,
    uart_alu_ctrl_if.master bus
);
    state_e          state_q, state_d;
    logic [DBIT-1:0] a_q, a_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] txd_q, txd_d;
    logic [OPW-1:0]  op_q, op_d;
    logic            ovr_q, ovr_d;
    logic            tmo_q, tmo_d;
    logic            accept;
    logic            expire;
    logic            tx_start;
    logic            busy;

`ifdef RX_TIMEOUT_EN
    logic gap_en;

    assign gap_en = (state_q == S_WAIT_B) || (state_q == S_WAIT_OP);

    uart_gap_timer #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_gap (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (accept || !gap_en),
        .enable_i (gap_en),
        .expire_o (expire)
    );
`else
    wire unused_timeout = |TIMEOUT_CYCLES;
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= S_WAIT_A;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            txd_q <= '0;
            ovr_q <= 1'b0;
            tmo_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            op_q  <= op_d;
            txd_q <= txd_d;
            ovr_q <= ovr_d;
            tmo_q <= tmo_d;
        end
    end

    // A byte arriving outside the receive states is dropped as overrun.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        txd_d   = txd_q;
        ovr_d   = 1'b0;
        tmo_d   = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            S_WAIT_A: begin
                if (bus.rx_done_tick) begin
                    a_d     = bus.rx_data;
                    accept  = 1'b1;
                    state_d = S_WAIT_B;
                end
            end
            S_WAIT_B: begin
                if (bus.rx_done_tick) begin
                    b_d     = bus.rx_data;
                    accept  = 1'b1;
                    state_d = S_WAIT_OP;
                end else if (expire) begin
                    tmo_d   = 1'b1;
                    state_d = S_WAIT_A;
                end
            end
            S_WAIT_OP: begin
                if (bus.rx_done_tick) begin
                    op_d    = bus.rx_data[OPW-1:0];
                    accept  = 1'b1;
                    state_d = S_EXEC;
                end else if (expire) begin
                    tmo_d   = 1'b1;
                    state_d = S_WAIT_A;
                end
            end
            S_EXEC: begin
                txd_d   = bus.alu_result;
                ovr_d   = bus.rx_done_tick;
                state_d = S_SEND;
            end
            S_SEND: begin
                ovr_d   = bus.rx_done_tick;
                state_d = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                ovr_d = bus.rx_done_tick;
                if (bus.tx_done_tick)
                    state_d = S_WAIT_A;
            end
            default: state_d = S_WAIT_A;
        endcase
    end

    always_comb begin
        tx_start = 1'b0;
        busy     = 1'b0;
        unique case (state_q)
            S_EXEC:    busy = 1'b1;
            S_SEND:    begin
                busy     = 1'b1;
                tx_start = 1'b1;
            end
            S_WAIT_TX: busy = 1'b1;
            default:   ;
        endcase
    end

    assign bus.alu_a        = a_q;
    assign bus.alu_b        = b_q;
    assign bus.alu_op       = op_q;
    assign bus.tx_data      = txd_q;
    assign bus.tx_start     = tx_start;
    assign bus.busy         = busy;
    assign bus.overrun_tick = ovr_q;
`ifdef RX_TIMEOUT_EN
    assign bus.timeout_tick = tmo_q;
`else
    assign bus.timeout_tick = 1'b0;
`endif

endmodule

// File: doc/uart_alu_ctrl.md
UART_ALU_CTRL -- requirements
Module: uart_alu_ctrl

Interface
REQ-001 Parameter DBIT, default 8: data byte width; shall be the width of every data port.
REQ-002 Parameter OPW, default 6: opcode width, taken from the low OPW bits of the opcode byte.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000000: allowed clk-cycle gap between operand/opcode bytes (used only with RX_TIMEOUT_EN).
REQ-004 Port clk, input, 1: single clock; all state changes on rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port rx_done_tick, input, 1: one-cycle pulse, received byte valid on rx_data.
REQ-007 Port rx_data, input, DBIT: received byte.
REQ-008 Port alu_result, input, DBIT: combinational ALU result for the current alu_a/alu_b/alu_op.
REQ-009 Port tx_done_tick, input, 1: one-cycle pulse, transmitter finished the byte.
REQ-010 Port alu_a, output, DBIT: registered operand A.
REQ-011 Port alu_b, output, DBIT: registered operand B.
REQ-012 Port alu_op, output, OPW: registered opcode.
REQ-013 Port tx_start, output, 1: one-cycle pulse requesting transmission of tx_data.
REQ-014 Port tx_data, output, DBIT: registered result byte, stable from tx_start until tx_done_tick.
REQ-015 Port busy, output, 1: high in EXEC, SEND, WAIT_TX.
REQ-016 Port overrun_tick, output, 1: one-cycle pulse when a received byte is dropped.
REQ-017 Port timeout_tick, output, 1: one-cycle pulse when a frame is aborted by timeout.

Function
REQ-018 FSM states: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
REQ-019 WAIT_A + rx_done_tick: alu_a <= rx_data; go WAIT_B. WAIT_B + rx_done_tick: alu_b <= rx_data; go WAIT_OP.
REQ-020 WAIT_OP + rx_done_tick: alu_op <= rx_data[OPW-1:0]; go EXEC.
REQ-021 EXEC (exactly one cycle): tx_data <= alu_result; go SEND.
REQ-022 SEND (exactly one cycle): tx_start = 1; go WAIT_TX.
REQ-023 WAIT_TX: hold until tx_done_tick, then go WAIT_A; tx_done_tick in any other state is ignored.
REQ-024 Latency: tx_start asserts exactly 2 cycles after the cycle in which the opcode byte's rx_done_tick is sampled.
REQ-025 rx_done_tick in EXEC, SEND or WAIT_TX: byte dropped, registers unchanged, overrun_tick = 1 the following cycle.
REQ-026 rx_done_tick and tx_done_tick in the same WAIT_TX cycle: go WAIT_A, byte dropped, overrun_tick pulses.
REQ-027 alu_a, alu_b, alu_op hold their values from capture until overwritten by the next frame.
REQ-028 All outputs are registered or decoded from state only; no combinational path from any input to any output.

Reset
REQ-029 reset forces WAIT_A immediately, at any point mid-frame or mid-transmission.
REQ-030 Reset values: alu_a, alu_b, tx_data = 0; alu_op = 0; tx_start, busy, overrun_tick, timeout_tick = 0; gap counter = 0.

Configuration
REQ-031 Macro RX_TIMEOUT_EN defined: gap counter clears on each accepted byte and on entry to WAIT_A, counts every cycle in WAIT_B and WAIT_OP.
REQ-032 With RX_TIMEOUT_EN, when the counter reaches TIMEOUT_CYCLES-1 without rx_done_tick, go WAIT_A; timeout_tick pulses one cycle; captured registers are retained.
REQ-033 With RX_TIMEOUT_EN, rx_done_tick in the same cycle as expiry takes priority: byte accepted, no timeout.
REQ-034 Without RX_TIMEOUT_EN: no counter logic; timeout_tick tied 0; frames wait indefinitely.

Structure
REQ-035 Shared package uart_pkg holds the state encoding, DBIT default and OPW default.
REQ-036 Gap counter is the sub-module uart_gap_timer (clear, enable, expire), instantiated only under RX_TIMEOUT_EN.

Verification
REQ-037 Bytes 0x05, 0x03, 0x20, ALU model alu_result = 0x08 -> tx_start 2 cycles after the third tick, tx_data = 0x08; tx_done_tick -> WAIT_A.
REQ-038 Byte 0x7F received during WAIT_TX -> overrun_tick pulses once; alu_a unchanged; next frame 0x01, 0x02, 0x22 processes normally.
REQ-039 reset asserted after the second byte -> WAIT_A; all outputs at reset values; a fresh three-byte frame completes.
REQ-040 RX_TIMEOUT_EN, TIMEOUT_CYCLES = 20, one byte then silence -> timeout_tick at gap cycle 19, state WAIT_A, no tx_start.
REQ-041 RX_TIMEOUT_EN, second byte arrives on the expiry cycle -> byte accepted, timeout_tick stays 0, state WAIT_OP.
REQ-042 Opcode byte 0xE5 with OPW = 6 -> alu_op = 0x25.
